// File: rtl/approx_add_pkg.sv
// Shared types and elaboration helpers for the pipelined approximate adder.
package approx_add_pkg;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'd0,
        MODE_COPY  = 2'd1,
        MODE_OR    = 2'd2,
        MODE_SPEC  = 2'd3
    } mode_e;

    function automatic int chunk_w(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    // Never returns zero so the K port stays legal when MAX_K is 0.
    function automatic int k_w(input int max_k);
        int w;
        w = $clog2(max_k + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/approx_add_stage.sv
// One pipeline slice: adds its chunk of the pre-conditioned operands and
// registers the running sum, the carry and everything later slices still need.
module approx_add_stage #(
    parameter int WIDTH = 8,
    parameter int CW    = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             carry_i,
    input  logic [WIDTH:0]   exact_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic [WIDTH:0]   exact_o
);

    localparam int LO = IDX * CW;
    localparam int HI = (LO + CW < WIDTH) ? (LO + CW) : WIDTH;

    logic             valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_q;
    logic             carry_d;
    logic [WIDTH:0]   exact_q;

    // Ripple add of this slice's bits. Approximated low bits arrive pre-placed
    // in sum_i with zeroed operands, so OR-ing keeps them intact.
    always_comb begin : chunk_add
        logic cy;
        cy    = carry_i;
        sum_d = sum_i;
        for (int i = LO; i < HI; i++) begin
            sum_d[i] = sum_i[i] | (a_i[i] ^ b_i[i] ^ cy);
            cy       = (a_i[i] & b_i[i]) | (cy & (a_i[i] ^ b_i[i]));
        end
        carry_d = cy;
    end

    // Slice registers; hold whenever the pipeline is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            exact_q <= {(WIDTH+1){1'b0}};
        end else if (en_i) begin
            valid_q <= valid_i;
            a_q     <= a_i;
            b_q     <= b_i;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            exact_q <= exact_i;
        end else begin
            valid_q <= valid_q;
            a_q     <= a_q;
            b_q     <= b_q;
            sum_q   <= sum_q;
            carry_q <= carry_q;
            exact_q <= exact_q;
        end
    end

    assign valid_o = valid_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign sum_o   = sum_q;
    assign carry_o = carry_q;
    assign exact_o = exact_q;

endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined approximate adder with per-beat mode/K selection, a valid/ready
// stream interface and an exact-sum error monitor.
module approx_add_pipe
    import approx_add_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int MAX_K  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_a,
    input  logic [WIDTH-1:0]        in_b,
    input  logic [1:0]              in_mode,
    input  logic [k_w(MAX_K)-1:0]   in_k,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH:0]          out_sum,
    input  logic                    stat_clr,
    output logic [CNT_W-1:0]        err_cnt,
    output logic [CNT_W-1:0]        tot_cnt,
    output logic [WIDTH:0]          max_err
);

    localparam int KW = k_w(MAX_K);
    localparam int CW = chunk_w(WIDTH, STAGES);

    mode_e            mode_s;
    logic [KW-1:0]    ke_s;
    logic [WIDTH-1:0] a_m_s;
    logic [WIDTH-1:0] b_m_s;
    logic [WIDTH-1:0] lo_s;
    logic [WIDTH:0]   exact_s;

    logic             vld_s   [STAGES+1];
    logic [WIDTH-1:0] a_s     [STAGES+1];
    logic [WIDTH-1:0] b_s     [STAGES+1];
    logic [WIDTH-1:0] sum_s   [STAGES+1];
    logic             cy_s    [STAGES+1];
    logic [WIDTH:0]   ex_s    [STAGES+1];

    logic             fire_s;
    logic [WIDTH:0]   exact_fin_s;
    logic [WIDTH:0]   diff_s;
    logic [CNT_W-1:0] tot_q;
    logic [CNT_W-1:0] tot_d;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] err_d;
    logic [WIDTH:0]   max_q;
    logic [WIDTH:0]   max_d;

    // Low-bit approximation. Approximated bits go straight into the initial
    // sum; their operand bits are zeroed except bit ke-1, where both operands
    // carry c so the exact high-part adder sees c as its carry-in.
    always_comb begin : low_bits
        logic c_bit;
        mode_s = mode_e'(in_mode);
        if (mode_s == MODE_EXACT) begin
            ke_s = {KW{1'b0}};
        end else if (in_k > KW'(MAX_K)) begin
            ke_s = KW'(MAX_K);
        end else begin
            ke_s = in_k;
        end
        a_m_s = in_a;
        b_m_s = in_b;
        lo_s  = {WIDTH{1'b0}};
        c_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < int'(ke_s)) begin
                case (mode_s)
                    MODE_COPY: lo_s[i] = in_b[i];
                    MODE_OR:   lo_s[i] = in_a[i] | in_b[i];
                    MODE_SPEC: lo_s[i] = in_a[i] ^ in_b[i];
                    default:   lo_s[i] = 1'b0;
                endcase
                if ((i == int'(ke_s) - 1) && (mode_s != MODE_COPY)) begin
                    c_bit = in_a[i] & in_b[i];
                end else begin
                    c_bit = 1'b0;
                end
                a_m_s[i] = c_bit;
                b_m_s[i] = c_bit;
            end else begin
                a_m_s[i] = in_a[i];
                b_m_s[i] = in_b[i];
            end
        end
        exact_s = {1'b0, in_a} + {1'b0, in_b};
    end

    assign in_ready = !out_valid || out_ready;

    assign vld_s[0] = in_valid;
    assign a_s[0]   = a_m_s;
    assign b_s[0]   = b_m_s;
    assign sum_s[0] = lo_s;
    assign cy_s[0]  = 1'b0;
    assign ex_s[0]  = exact_s;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        approx_add_stage #(
            .WIDTH (WIDTH),
            .CW    (CW),
            .IDX   (s)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (in_ready),
            .valid_i (vld_s[s]),
            .a_i     (a_s[s]),
            .b_i     (b_s[s]),
            .sum_i   (sum_s[s]),
            .carry_i (cy_s[s]),
            .exact_i (ex_s[s]),
            .valid_o (vld_s[s+1]),
            .a_o     (a_s[s+1]),
            .b_o     (b_s[s+1]),
            .sum_o   (sum_s[s+1]),
            .carry_o (cy_s[s+1]),
            .exact_o (ex_s[s+1])
        );
    end

    assign out_valid   = vld_s[STAGES];
    assign out_sum     = {cy_s[STAGES], sum_s[STAGES]};
    assign exact_fin_s = ex_s[STAGES];
    assign fire_s      = out_valid && out_ready;

    // Absolute error of the result currently presented.
    always_comb begin
        if (exact_fin_s >= out_sum) begin
            diff_s = exact_fin_s - out_sum;
        end else begin
            diff_s = out_sum - exact_fin_s;
        end
    end

    // Statistics next state; a clear overrides a coincident transfer.
    always_comb begin
        tot_d = tot_q;
        err_d = err_q;
        max_d = max_q;
        if (stat_clr) begin
            tot_d = {CNT_W{1'b0}};
            err_d = {CNT_W{1'b0}};
            max_d = {(WIDTH+1){1'b0}};
        end else if (fire_s) begin
            if (tot_q != {CNT_W{1'b1}}) begin
                tot_d = tot_q + CNT_W'(1);
            end else begin
                tot_d = tot_q;
            end
            if ((diff_s != {(WIDTH+1){1'b0}}) && (err_q != {CNT_W{1'b1}})) begin
                err_d = err_q + CNT_W'(1);
            end else begin
                err_d = err_q;
            end
            if (diff_s > max_q) begin
                max_d = diff_s;
            end else begin
                max_d = max_q;
            end
        end else begin
            tot_d = tot_q;
            err_d = err_q;
            max_d = max_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tot_q <= {CNT_W{1'b0}};
            err_q <= {CNT_W{1'b0}};
            max_q <= {(WIDTH+1){1'b0}};
        end else begin
            tot_q <= tot_d;
            err_q <= err_d;
            max_q <= max_d;
        end
    end

    assign tot_cnt = tot_q;
    assign err_cnt = err_q;
    assign max_err = max_q;

endmodule
